if_id_pipe: RTL and testbench
=============================

Name: if_id_pipe

Overview:
- Parametrised IF→ID pipeline register; next generation of the plain IF/ID latch.
- Adds valid/ready handshake on both sides, a stall input from the hazard unit, a flush input from branch/exception resolution, and a 2-entry skid buffer so that `if_ready` is a pure register output.
- Provides a saturating stall-cycle counter for performance monitoring.
- Sits between the fetch stage (PC + instruction memory) and the decode stage.

Parameters:
- ADDR_W, 32, width of PC fields.
- INST_W, 32, width of instruction fields.
- NOP_INST, 0, instruction word presented to decode when no valid instruction is held (all-zero = MIPS sll $0,$0,0).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_valid  in  1  fetch presents a valid pc/inst pair this cycle.
- if_ready  out  1  stage can accept a pair; registered output.
- if_pc  in  ADDR_W  fetched instruction address.
- if_inst  in  INST_W  fetched instruction word.
- id_valid  out  1  id_pc/id_inst hold a valid instruction.
- id_ready  in  1  decode can consume this cycle.
- id_pc  out  ADDR_W  instruction address to decode.
- id_inst  out  INST_W  instruction word to decode.
- stall  in  1  hazard stall; while high, nothing leaves the stage.
- flush  in  1  discard all held and incoming instructions.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
Storage and reset
- Two entries: main (drives id_*) and skid.
- Async reset while rst=0: main/skid valid=0, id_pc=0, id_inst=NOP_INST, if_ready=1, stall_cnt=0.
- Reset may assert in any cycle and overrides all other inputs.

Handshake definitions
- Accept: `take_in = if_valid & if_ready`.
- Drain: `take_out = id_valid & id_ready & ~stall`.
- `id_valid` = main valid.
- When main is invalid, id_inst=NOP_INST and id_pc=0, so decode sees a bubble.

Per rising edge (no flush)
- take_out and main then empty:
  - Skid valid → skid moves to main.
  - Else take_in → input loads main.
  - Else main becomes invalid.
- Main valid and not take_out:
  - take_in → input goes to skid (skid was empty, because if_ready was 1).
- Main invalid and take_in → input loads main.
- take_out and take_in with skid valid: impossible, because if_ready=0.
- Latency: an accepted pair appears on id_* the cycle after acceptance when main is free or draining; order is strictly FIFO.
- if_ready next = NOT (skid valid next). With a full skid it deasserts the cycle after the skid fills and reasserts the cycle after the skid drains.

Flush
- Next edge: main and skid invalid, id_inst=NOP_INST, id_pc=0, if_ready=1.
- A pair accepted in the flush cycle is discarded.
- Flush has priority over stall and over take_in/take_out.

Stall
- stall=1 freezes main and skid contents; take_in into an empty slot is still permitted.

stall_cnt
- Increments each cycle with id_valid=1 AND (stall=1 OR id_ready=0).
- Saturates at 2^CNT_W−1; no wrap.
- Unaffected by flush; cleared only by reset.

Width rules
- Pure storage; no arithmetic on pc/inst.

Test Plan:
- Reset release, if_valid=0 → id_valid=0, id_inst=NOP_INST, id_pc=0, if_ready=1, stall_cnt=0.
- Stream pc=0x00,0x04,0x08 with insts 0x24010001, 0x24020002, 0x00221820, id_ready=1 → each appears one cycle after acceptance, in order, no gaps.
- id_ready=0 for 3 cycles while fetch streams:
  - main holds 0x00 and skid takes 0x04; if_ready drops next cycle; stall_cnt=3.
  - After release, 0x04 then 0x08 emerge with no loss or duplication.
- stall=1 with main and skid full, then flush=1 with if_valid=1 → next cycle id_valid=0, id_inst=0, if_ready=1; the flush-cycle input never appears on id_*.
- CNT_W=4, id_ready=0 for 20 cycles with id_valid=1 → stall_cnt stops at 15.
- Assert rst=0 asynchronously mid-clock while main and skid are full → outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF->ID pipeline register with valid/ready handshake and 2-entry skid buffer
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   if_valid      fetch presents a pc/inst pair
//   if_ready      stage can accept a pair (registered)
//   if_pc/if_inst fetched address and instruction word
//   id_valid      id_pc/id_inst hold a valid instruction
//   id_ready      decode can consume this cycle
//   id_pc/id_inst instruction to decode (0 / NOP_INST when invalid)
//   stall         hazard stall; nothing leaves the stage while high
//   flush         discard all held and incoming instructions
//   stall_cnt     saturating count of cycles a valid instruction was held back
module if_id_pipe #(
  parameter int unsigned             ADDR_W   = 32,
  parameter int unsigned             INST_W   = 32,
  parameter logic [INST_W-1:0]       NOP_INST = '0,
  parameter int unsigned             CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_vld_q, main_vld_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic              skid_vld_q, skid_vld_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic take_in;
  logic take_out;

  assign take_in  = if_valid & rdy_q;
  assign take_out = main_vld_q & id_ready & ~stall;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_vld_d  = skid_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      main_vld_d  = 1'b0;
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
      skid_vld_d  = 1'b0;
    end else if (take_out) begin
      if (skid_vld_q) begin
        // Skid holds the older entry; take_in cannot occur here since if_ready=0.
        main_vld_d  = 1'b1;
        main_pc_d   = skid_pc_q;
        main_inst_d = skid_inst_q;
        skid_vld_d  = 1'b0;
      end else if (take_in) begin
        main_vld_d  = 1'b1;
        main_pc_d   = if_pc;
        main_inst_d = if_inst;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (take_in) begin
      if (main_vld_q) begin
        // Main is held (stall or decode not ready): park the new pair in skid.
        skid_vld_d  = 1'b1;
        skid_pc_d   = if_pc;
        skid_inst_d = if_inst;
      end else begin
        main_vld_d  = 1'b1;
        main_pc_d   = if_pc;
        main_inst_d = if_inst;
      end
    end

    // if_ready only needs the next skid occupancy, so it stays a flop output.
    rdy_d = ~skid_vld_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (main_vld_q && (stall || !id_ready) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld_q  <= 1'b0;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_vld_q  <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      rdy_q       <= 1'b1;
      cnt_q       <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_vld_q  <= skid_vld_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      rdy_q       <= rdy_d;
      cnt_q       <= cnt_d;
    end
  end

  // Invalid main is presented as a bubble regardless of stale register contents.
  assign id_valid  = main_vld_q;
  assign id_pc     = main_vld_q ? main_pc_q : '0;
  assign id_inst   = main_vld_q ? main_inst_q : NOP_INST;
  assign if_ready  = rdy_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - directed self-checking bench for if_id_pipe
module tb_if_id_pipe;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        stall;
  logic        flush;
  logic [3:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  if_id_pipe #(
    .ADDR_W  (32),
    .INST_W  (32),
    .NOP_INST(32'h0),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .stall    (stall),
    .flush    (flush),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {31'b0, id_valid}, {31'b0, v});
    check({tag, "_pc"}, id_pc, pc);
    check({tag, "_inst"}, id_inst, inst);
  endtask

  initial begin
    rst      = 1'b0;
    if_valid = 1'b0;
    if_pc    = '0;
    if_inst  = '0;
    id_ready = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check_id("reset", 1'b0, 32'h0, 32'h0);
    check("reset_if_ready", {31'b0, if_ready}, 32'd1);
    check("reset_cnt", {28'b0, stall_cnt}, 32'd0);

    // Streaming with decode always ready
    id_ready = 1'b1;
    if_valid = 1'b1; if_pc = 32'h00; if_inst = 32'h24010001;
    step();
    check_id("s0", 1'b1, 32'h00, 32'h24010001);
    if_pc = 32'h04; if_inst = 32'h24020002;
    step();
    check_id("s1", 1'b1, 32'h04, 32'h24020002);
    if_pc = 32'h08; if_inst = 32'h00221820;
    step();
    check_id("s2", 1'b1, 32'h08, 32'h00221820);
    if_valid = 1'b0;
    step();
    check_id("s_empty", 1'b0, 32'h0, 32'h0);
    check("s_cnt", {28'b0, stall_cnt}, 32'd0);

    // Decode back-pressure for three held cycles
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h00; if_inst = 32'h24010001;
    step();
    check_id("bp_load", 1'b1, 32'h00, 32'h24010001);
    check("bp_rdy0", {31'b0, if_ready}, 32'd1);
    if_pc = 32'h04; if_inst = 32'h24020002;
    step();
    check("bp_rdy_drop", {31'b0, if_ready}, 32'd0);
    check("bp_cnt1", {28'b0, stall_cnt}, 32'd1);
    check_id("bp_hold", 1'b1, 32'h00, 32'h24010001);
    if_pc = 32'h08; if_inst = 32'h00221820;
    step();
    step();
    check("bp_cnt3", {28'b0, stall_cnt}, 32'd3);
    check_id("bp_hold3", 1'b1, 32'h00, 32'h24010001);
    check("bp_rdy_low", {31'b0, if_ready}, 32'd0);
    id_ready = 1'b1;
    step();
    check_id("bp_out4", 1'b1, 32'h04, 32'h24020002);
    check("bp_rdy_back", {31'b0, if_ready}, 32'd1);
    check("bp_cnt_keep", {28'b0, stall_cnt}, 32'd3);
    step();
    check_id("bp_out8", 1'b1, 32'h08, 32'h00221820);
    if_valid = 1'b0;
    step();
    check_id("bp_drained", 1'b0, 32'h0, 32'h0);

    // Stall with both entries full, then flush with fetch still valid
    stall = 1'b1;
    if_valid = 1'b1; if_pc = 32'h10; if_inst = 32'h11111111;
    step();
    check_id("st_load", 1'b1, 32'h10, 32'h11111111);
    if_pc = 32'h14; if_inst = 32'h22222222;
    step();
    check("st_rdy", {31'b0, if_ready}, 32'd0);
    check("st_cnt4", {28'b0, stall_cnt}, 32'd4);
    step();
    check_id("st_frozen", 1'b1, 32'h10, 32'h11111111);
    check("st_cnt5", {28'b0, stall_cnt}, 32'd5);
    flush = 1'b1; if_pc = 32'h18; if_inst = 32'h33333333;
    step();
    check_id("fl", 1'b0, 32'h0, 32'h0);
    check("fl_rdy", {31'b0, if_ready}, 32'd1);
    check("fl_cnt", {28'b0, stall_cnt}, 32'd6);
    flush = 1'b0; stall = 1'b0; if_valid = 1'b0;
    step();
    check_id("fl_after", 1'b0, 32'h0, 32'h0);
    // A pair accepted in the flush cycle itself is dropped
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h1C; if_inst = 32'h44444444;
    step();
    flush = 1'b0; if_valid = 1'b0;
    check_id("fl_accept", 1'b0, 32'h0, 32'h0);
    step();
    check_id("fl_accept2", 1'b0, 32'h0, 32'h0);

    // Counter saturation at 15 with CNT_W=4
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h20; if_inst = 32'h55555555;
    step();
    if_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("sat_14", {28'b0, stall_cnt}, 32'd14);
    for (int i = 0; i < 12; i++) step();
    check("sat_15", {28'b0, stall_cnt}, 32'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_flush_keep", {28'b0, stall_cnt}, 32'd15);

    // Asynchronous reset mid-clock with main and skid full
    if_valid = 1'b1; if_pc = 32'h30; if_inst = 32'h66666666;
    step();
    if_pc = 32'h34; if_inst = 32'h77777777;
    step();
    if_valid = 1'b0;
    check("ar_full_rdy", {31'b0, if_ready}, 32'd0);
    check_id("ar_full", 1'b1, 32'h30, 32'h66666666);
    #2;
    rst = 1'b0;
    #1;
    check_id("ar", 1'b0, 32'h0, 32'h0);
    check("ar_rdy", {31'b0, if_ready}, 32'd1);
    check("ar_cnt", {28'b0, stall_cnt}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check_id("ar_release", 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
